l1_axi_responder: RTL and testbench

- AXI4 slave that terminates the 32-bit `l1` master interface driven by task units (the `m_axi_l1_V_*` bus).
- Backs the interface with on-chip word memory, DEPTH_WORDS deep.
- Serves single-beat and incrementing-burst reads and single-beat byte-strobed writes.
- Used as the L1 model in unit-level benches and as a scratchpad in small configs.
- One read and one write transaction in flight at a time; the read and write channels are independent.

---
 rtl/l1_axi_responder_pkg.sv | 20 ++
 rtl/l1_axi_responder_if.sv | 54 +++++
 rtl/l1_axi_responder_chk.sv | 12 +
 rtl/l1_resp_ram.sv | 31 +++
 rtl/l1_axi_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_l1_axi_responder.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/l1_axi_responder_pkg.sv
// Shared types and constants for the l1 AXI responder.
package chronos;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } l1_rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_MEM  = 2'd1,
        W_RESP = 2'd2
    } l1_wr_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_32     = 3'b010;

endpackage

// File: rtl/l1_axi_responder_if.sv
// AXI4 l1 bus as seen between a task-unit master and the l1 responder.
interface l1_axi_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  s_axi_l1_V_AWVALID;
    logic                  s_axi_l1_V_AWREADY;
    logic [ADDR_WIDTH-1:0] s_axi_l1_V_AWADDR;
    logic [7:0]            s_axi_l1_V_AWLEN;
    logic [2:0]            s_axi_l1_V_AWSIZE;
    logic                  s_axi_l1_V_WVALID;
    logic                  s_axi_l1_V_WREADY;
    logic [31:0]           s_axi_l1_V_WDATA;
    logic [3:0]            s_axi_l1_V_WSTRB;
    logic                  s_axi_l1_V_WLAST;
    logic                  s_axi_l1_V_BVALID;
    logic                  s_axi_l1_V_BREADY;
    logic [1:0]            s_axi_l1_V_BRESP;
    logic                  s_axi_l1_V_BID;
    logic                  s_axi_l1_V_ARVALID;
    logic                  s_axi_l1_V_ARREADY;
    logic [ADDR_WIDTH-1:0] s_axi_l1_V_ARADDR;
    logic [7:0]            s_axi_l1_V_ARLEN;
    logic [2:0]            s_axi_l1_V_ARSIZE;
    logic                  s_axi_l1_V_RVALID;
    logic                  s_axi_l1_V_RREADY;
    logic [31:0]           s_axi_l1_V_RDATA;
    logic                  s_axi_l1_V_RLAST;
    logic [1:0]            s_axi_l1_V_RRESP;
    logic                  s_axi_l1_V_RID;

    modport slave (
        input  s_axi_l1_V_AWVALID, s_axi_l1_V_AWADDR, s_axi_l1_V_AWLEN, s_axi_l1_V_AWSIZE,
        input  s_axi_l1_V_WVALID, s_axi_l1_V_WDATA, s_axi_l1_V_WSTRB, s_axi_l1_V_WLAST,
        input  s_axi_l1_V_BREADY,
        input  s_axi_l1_V_ARVALID, s_axi_l1_V_ARADDR, s_axi_l1_V_ARLEN, s_axi_l1_V_ARSIZE,
        input  s_axi_l1_V_RREADY,
        output s_axi_l1_V_AWREADY, s_axi_l1_V_WREADY,
        output s_axi_l1_V_BVALID, s_axi_l1_V_BRESP, s_axi_l1_V_BID,
        output s_axi_l1_V_ARREADY,
        output s_axi_l1_V_RVALID, s_axi_l1_V_RDATA, s_axi_l1_V_RLAST, s_axi_l1_V_RRESP, s_axi_l1_V_RID
    );

    modport master (
        output s_axi_l1_V_AWVALID, s_axi_l1_V_AWADDR, s_axi_l1_V_AWLEN, s_axi_l1_V_AWSIZE,
        output s_axi_l1_V_WVALID, s_axi_l1_V_WDATA, s_axi_l1_V_WSTRB, s_axi_l1_V_WLAST,
        output s_axi_l1_V_BREADY,
        output s_axi_l1_V_ARVALID, s_axi_l1_V_ARADDR, s_axi_l1_V_ARLEN, s_axi_l1_V_ARSIZE,
        output s_axi_l1_V_RREADY,
        input  s_axi_l1_V_AWREADY, s_axi_l1_V_WREADY,
        input  s_axi_l1_V_BVALID, s_axi_l1_V_BRESP, s_axi_l1_V_BID,
        input  s_axi_l1_V_ARREADY,
        input  s_axi_l1_V_RVALID, s_axi_l1_V_RDATA, s_axi_l1_V_RLAST, s_axi_l1_V_RRESP, s_axi_l1_V_RID
    );
endinterface

// File: rtl/l1_axi_responder_chk.sv
// Protocol checks on the l1 write channel: only single-beat writes are supported.
module l1_axi_responder_chk (
    input logic       clk_i,
    input logic       rst_i,
    input logic       aw_hs_i,
    input logic [7:0] awlen_i,
    input logic       w_hs_i,
    input logic       wlast_i
);
    a_awlen_single: assert property (@(posedge clk_i) disable iff (rst_i) aw_hs_i |-> (awlen_i == 8'd0));
    a_wlast_set:    assert property (@(posedge clk_i) disable iff (rst_i) w_hs_i |-> wlast_i);
endmodule

// File: rtl/l1_resp_ram.sv
// Word memory for the l1 responder: one registered read port, one byte-enabled write port.
module l1_resp_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = 12
) (
    input  logic             clk_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [3:0]       wr_be_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Read samples the array before the same-edge write lands, so a colliding read sees the old word.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en_i && wr_be_i[b]) begin
                mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/l1_axi_responder.sv
// l1 AXI4 slave backed by on-chip word memory; independent read and write FSMs.
// Define L1_RESP_STATS_EN to add the stat_rd_beats / stat_wr_cnt / stat_err_cnt counters.
module l1_axi_responder
    import chronos::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    l1_axi_responder_if.slave axi
`ifdef L1_RESP_STATS_EN
    ,
    output logic [31:0]       stat_rd_beats,
    output logic [31:0]       stat_wr_cnt,
    output logic [15:0]       stat_err_cnt
`endif
);
    localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

    function automatic logic idx_oor(input logic [ADDR_WIDTH-3:0] word_idx);
        return word_idx >= DEPTH_IDX;
    endfunction

    l1_rd_state_t          rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]            rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
    logic                  rd_err_q, rd_err_d, rd_size_bad_q, rd_size_bad_d;
    logic                  rd_fetch_s, rd_last_s;
    logic [31:0]           ram_rdata_s;

    l1_wr_state_t          wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [3:0]            wr_strb_q, wr_strb_d;
    logic                  wr_err_q, wr_err_d, wr_mem_s;

    assign rd_last_s = (rd_beat_q == rd_len_q);

    // Read FSM next state: error is re-evaluated on every beat so bursts can cross the memory end.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_addr_d     = rd_addr_q;
        rd_len_d      = rd_len_q;
        rd_beat_d     = rd_beat_q;
        rd_err_d      = rd_err_q;
        rd_size_bad_d = rd_size_bad_q;
        rd_fetch_s    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (axi.s_axi_l1_V_ARVALID) begin
                    rd_addr_d     = axi.s_axi_l1_V_ARADDR;
                    rd_len_d      = axi.s_axi_l1_V_ARLEN;
                    rd_beat_d     = 8'd0;
                    rd_size_bad_d = (axi.s_axi_l1_V_ARSIZE != AXI_SIZE_32);
                    rd_err_d      = rd_size_bad_d | idx_oor(axi.s_axi_l1_V_ARADDR[ADDR_WIDTH-1:2]);
                    rd_state_d    = R_FETCH;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_FETCH: begin
                rd_fetch_s = 1'b1;
                rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi.s_axi_l1_V_RREADY) begin
                    if (rd_last_s) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_addr_d  = rd_addr_q + ADDR_STEP;
                        rd_beat_d  = rd_beat_q + 8'd1;
                        rd_err_d   = rd_size_bad_q | idx_oor(rd_addr_d[ADDR_WIDTH-1:2]);
                        rd_state_d = R_FETCH;
                    end
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state: AW and W are captured independently, then one memory cycle, then B.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        wr_err_d   = wr_err_q;
        wr_mem_s   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (axi.s_axi_l1_V_AWVALID && !aw_held_q) begin
                    aw_held_d = 1'b1;
                    wr_idx_d  = axi.s_axi_l1_V_AWADDR[IDX_W+1:2];
                    wr_err_d  = (axi.s_axi_l1_V_AWSIZE != AXI_SIZE_32) |
                                idx_oor(axi.s_axi_l1_V_AWADDR[ADDR_WIDTH-1:2]);
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (axi.s_axi_l1_V_WVALID && !w_held_q) begin
                    w_held_d  = 1'b1;
                    wr_data_d = axi.s_axi_l1_V_WDATA;
                    wr_strb_d = axi.s_axi_l1_V_WSTRB;
                end else begin
                    w_held_d = w_held_q;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = W_MEM;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_MEM: begin
                wr_mem_s   = !wr_err_q;
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (axi.s_axi_l1_V_BREADY) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // State and holding registers; memory contents are deliberately left untouched by reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_state_q    <= R_IDLE;
            rd_addr_q     <= '0;
            rd_len_q      <= 8'd0;
            rd_beat_q     <= 8'd0;
            rd_err_q      <= 1'b0;
            rd_size_bad_q <= 1'b0;
            wr_state_q    <= W_IDLE;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            wr_idx_q      <= '0;
            wr_data_q     <= 32'd0;
            wr_strb_q     <= 4'd0;
            wr_err_q      <= 1'b0;
        end else begin
            rd_state_q    <= rd_state_d;
            rd_addr_q     <= rd_addr_d;
            rd_len_q      <= rd_len_d;
            rd_beat_q     <= rd_beat_d;
            rd_err_q      <= rd_err_d;
            rd_size_bad_q <= rd_size_bad_d;
            wr_state_q    <= wr_state_d;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            wr_idx_q      <= wr_idx_d;
            wr_data_q     <= wr_data_d;
            wr_strb_q     <= wr_strb_d;
            wr_err_q      <= wr_err_d;
        end
    end

    l1_resp_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
        .clk_i     (ap_clk),
        .rd_en_i   (rd_fetch_s),
        .rd_idx_i  (rd_addr_q[IDX_W+1:2]),
        .rd_data_o (ram_rdata_s),
        .wr_en_i   (wr_mem_s),
        .wr_be_i   (wr_strb_q),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (wr_data_q)
    );

    l1_axi_responder_chk u_chk (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .aw_hs_i (axi.s_axi_l1_V_AWVALID & axi.s_axi_l1_V_AWREADY),
        .awlen_i (axi.s_axi_l1_V_AWLEN),
        .w_hs_i  (axi.s_axi_l1_V_WVALID & axi.s_axi_l1_V_WREADY),
        .wlast_i (axi.s_axi_l1_V_WLAST)
    );

    assign axi.s_axi_l1_V_ARREADY = (rd_state_q == R_IDLE);
    assign axi.s_axi_l1_V_RVALID  = (rd_state_q == R_DATA);
    assign axi.s_axi_l1_V_RDATA   = ((rd_state_q == R_DATA) && !rd_err_q) ? ram_rdata_s : 32'd0;
    assign axi.s_axi_l1_V_RRESP   = ((rd_state_q == R_DATA) && rd_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign axi.s_axi_l1_V_RLAST   = (rd_state_q == R_DATA) && rd_last_s;
    assign axi.s_axi_l1_V_RID     = 1'b0;
    assign axi.s_axi_l1_V_AWREADY = (wr_state_q == W_IDLE) && !aw_held_q;
    assign axi.s_axi_l1_V_WREADY  = (wr_state_q == W_IDLE) && !w_held_q;
    assign axi.s_axi_l1_V_BVALID  = (wr_state_q == W_RESP);
    assign axi.s_axi_l1_V_BRESP   = ((wr_state_q == W_RESP) && wr_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign axi.s_axi_l1_V_BID     = 1'b0;

`ifdef L1_RESP_STATS_EN
    logic        rd_hs_s, wr_hs_s;
    logic [16:0] err_sum_s;

    assign rd_hs_s   = axi.s_axi_l1_V_RVALID & axi.s_axi_l1_V_RREADY;
    assign wr_hs_s   = axi.s_axi_l1_V_BVALID & axi.s_axi_l1_V_BREADY;
    assign err_sum_s = {1'b0, stat_err_cnt} + 17'(rd_hs_s & rd_err_q) + 17'(wr_hs_s & wr_err_q);

    // Handshake statistics: beat/response counters wrap, the error counter saturates.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            stat_rd_beats <= 32'd0;
            stat_wr_cnt   <= 32'd0;
            stat_err_cnt  <= 16'd0;
        end else begin
            stat_rd_beats <= stat_rd_beats + 32'(rd_hs_s);
            stat_wr_cnt   <= stat_wr_cnt + 32'(wr_hs_s);
            stat_err_cnt  <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_l1_axi_responder.sv
// Randomized bench for l1_axi_responder against a word-array reference model.
module tb_l1_axi_responder;
    import chronos::*;

    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic ap_clk = 1'b0;
    logic ap_rst;
    l1_axi_responder_if #(.ADDR_WIDTH(AW)) axi ();
`ifdef L1_RESP_STATS_EN
    logic [31:0] stat_rd_beats, stat_wr_cnt;
    logic [15:0] stat_err_cnt;
`endif

    l1_axi_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .axi    (axi)
`ifdef L1_RESP_STATS_EN
        ,
        .stat_rd_beats (stat_rd_beats),
        .stat_wr_cnt   (stat_wr_cnt),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem_m [DEPTH];
    int          exp_rd_beats = 0;
    int          exp_wr_cnt   = 0;
    int          exp_err_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic bit addr_err(input logic [31:0] addr, input logic [2:0] size);
        return (size != 3'b010) || ((addr >> 2) >= 32'(DEPTH));
    endfunction

    task automatic do_reset();
        axi.s_axi_l1_V_ARVALID = 1'b0;
        axi.s_axi_l1_V_AWVALID = 1'b0;
        axi.s_axi_l1_V_WVALID  = 1'b0;
        axi.s_axi_l1_V_RREADY  = 1'b0;
        axi.s_axi_l1_V_BREADY  = 1'b0;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        exp_rd_beats = 0;
        exp_wr_cnt   = 0;
        exp_err_cnt  = 0;
        check_eq("rst_arready", axi.s_axi_l1_V_ARREADY, 32'd1);
        check_eq("rst_awready", axi.s_axi_l1_V_AWREADY, 32'd1);
        check_eq("rst_wready",  axi.s_axi_l1_V_WREADY,  32'd1);
        check_eq("rst_rvalid",  axi.s_axi_l1_V_RVALID,  32'd0);
        check_eq("rst_bvalid",  axi.s_axi_l1_V_BVALID,  32'd0);
        check_eq("rst_rlast",   axi.s_axi_l1_V_RLAST,   32'd0);
        check_eq("rst_rresp",   axi.s_axi_l1_V_RRESP,   32'd0);
        check_eq("rst_bresp",   axi.s_axi_l1_V_BRESP,   32'd0);
        check_eq("rst_rdata",   axi.s_axi_l1_V_RDATA,   32'd0);
    endtask

    // w_lead: cycles W is presented before AW; do_b=0 leaves the response pending.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [2:0] size, input int w_lead, input bit do_b);
        bit aw_done, w_done, aw_hs, w_hs, err;
        int n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        axi.s_axi_l1_V_AWADDR = addr;
        axi.s_axi_l1_V_AWLEN  = 8'd0;
        axi.s_axi_l1_V_AWSIZE = size;
        axi.s_axi_l1_V_WDATA  = data;
        axi.s_axi_l1_V_WSTRB  = strb;
        axi.s_axi_l1_V_WLAST  = 1'b1;
        for (int c = 0; c < 32 && !(aw_done && w_done); c++) begin
            axi.s_axi_l1_V_AWVALID = !aw_done && (c >= w_lead);
            axi.s_axi_l1_V_WVALID  = !w_done;
            aw_hs = axi.s_axi_l1_V_AWVALID && axi.s_axi_l1_V_AWREADY;
            w_hs  = axi.s_axi_l1_V_WVALID && axi.s_axi_l1_V_WREADY;
            tick();
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            if (w_done && !aw_done) check_eq("wready_held", axi.s_axi_l1_V_WREADY, 32'd0);
        end
        axi.s_axi_l1_V_AWVALID = 1'b0;
        axi.s_axi_l1_V_WVALID  = 1'b0;
        check_eq("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
        err = addr_err(addr, size);
        n = 0;
        while (!axi.s_axi_l1_V_BVALID && n < 16) begin
            tick();
            n++;
        end
        check_eq("b_latency", 32'(n), 32'd1);
        check_eq("bresp", axi.s_axi_l1_V_BRESP, err ? 32'd2 : 32'd0);
        check_eq("bid", axi.s_axi_l1_V_BID, 32'd0);
        if (!err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_m[addr >> 2][8*b +: 8] = data[8*b +: 8];
            end
        end
        if (do_b) begin
            axi.s_axi_l1_V_BREADY = 1'b1;
            tick();
            axi.s_axi_l1_V_BREADY = 1'b0;
            check_eq("bvalid_clear", axi.s_axi_l1_V_BVALID, 32'd0);
            exp_wr_cnt++;
            if (err) exp_err_cnt++;
        end
    endtask

    // stall_mode: 0 never stall, 1 one stall cycle per beat, 2 random 0..2; returns early at abort_beat.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int stall_mode, input int abort_beat);
        logic [31:0] a, exp_d;
        bit err;
        int n, stall;
        a = addr;
        check_eq("arready_idle", axi.s_axi_l1_V_ARREADY, 32'd1);
        axi.s_axi_l1_V_ARADDR  = addr;
        axi.s_axi_l1_V_ARLEN   = len;
        axi.s_axi_l1_V_ARSIZE  = size;
        axi.s_axi_l1_V_ARVALID = 1'b1;
        axi.s_axi_l1_V_RREADY  = 1'b0;
        tick();
        axi.s_axi_l1_V_ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!axi.s_axi_l1_V_RVALID && n < 16) begin
                tick();
                n++;
            end
            check_eq("r_gap", 32'(n), 32'd1);
            err   = addr_err(a, size);
            exp_d = err ? 32'd0 : mem_m[a >> 2];
            check_eq("rdata", axi.s_axi_l1_V_RDATA, exp_d);
            check_eq("rresp", axi.s_axi_l1_V_RRESP, err ? 32'd2 : 32'd0);
            check_eq("rlast", axi.s_axi_l1_V_RLAST, 32'(b == int'(len)));
            check_eq("rid", axi.s_axi_l1_V_RID, 32'd0);
            if (b == abort_beat) return;
            stall = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 1 : int'($urandom_range(0, 2));
            for (int s = 0; s < stall; s++) begin
                tick();
                check_eq("rvalid_stable", axi.s_axi_l1_V_RVALID, 32'd1);
                check_eq("rdata_stable", axi.s_axi_l1_V_RDATA, exp_d);
                check_eq("rlast_stable", axi.s_axi_l1_V_RLAST, 32'(b == int'(len)));
            end
            axi.s_axi_l1_V_RREADY = 1'b1;
            tick();
            axi.s_axi_l1_V_RREADY = 1'b0;
            exp_rd_beats++;
            if (err) exp_err_cnt++;
            a = a + 32'd4;
        end
        check_eq("r_end_idle", axi.s_axi_l1_V_RVALID, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op, idx;
        logic [31:0] ad;
        logic [2:0]  sz;
        axi.s_axi_l1_V_AWVALID = 1'b0;
        axi.s_axi_l1_V_AWADDR  = 32'd0;
        axi.s_axi_l1_V_AWLEN   = 8'd0;
        axi.s_axi_l1_V_AWSIZE  = 3'b010;
        axi.s_axi_l1_V_WVALID  = 1'b0;
        axi.s_axi_l1_V_WDATA   = 32'd0;
        axi.s_axi_l1_V_WSTRB   = 4'h0;
        axi.s_axi_l1_V_WLAST   = 1'b1;
        axi.s_axi_l1_V_BREADY  = 1'b0;
        axi.s_axi_l1_V_ARVALID = 1'b0;
        axi.s_axi_l1_V_ARADDR  = 32'd0;
        axi.s_axi_l1_V_ARLEN   = 8'd0;
        axi.s_axi_l1_V_ARSIZE  = 3'b010;
        axi.s_axi_l1_V_RREADY  = 1'b0;
        ap_rst = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        do_reset();

        // Give every word a known value so all later reads are defined.
        for (int i = 0; i < DEPTH; i++) axi_write(32'(i * 4), $urandom, 4'hF, 3'b010, 0, 1'b1);

        axi_write(32'h40, 32'hDEADBEEF, 4'hF, 3'b010, 0, 1'b1);
        axi_read(32'h40, 8'd0, 3'b010, 0, -1);

        for (int i = 0; i < 4; i++) axi_write(32'h100 + 32'(i * 4), 32'(i + 1), 4'hF, 3'b010, 0, 1'b1);
        axi_read(32'h100, 8'd3, 3'b010, 1, -1);

        axi_write(32'h200, 32'h11223344, 4'hF, 3'b010, 3, 1'b1);
        axi_read(32'h200, 8'd0, 3'b010, 0, -1);
        axi_write(32'h204, 32'hFFFFFFFF, 4'hF, 3'b010, 0, 1'b1);
        axi_write(32'h204, 32'h0000AB00, 4'b0010, 3'b010, 1, 1'b1);
        axi_read(32'h204, 8'd0, 3'b010, 0, -1);
        check_eq("strobe_merge_model", mem_m[32'h204 >> 2], 32'hFFFFABFF);

        axi_read(32'(DEPTH * 4 - 4), 8'd1, 3'b010, 0, -1);
        axi_write(32'h0, 32'h5A5A5A5A, 4'hF, 3'b010, 0, 1'b1);
        axi_write(32'(DEPTH * 4), 32'h12345678, 4'hF, 3'b010, 0, 1'b1);
        axi_read(32'h0, 8'd0, 3'b010, 0, -1);

        axi_write(32'h300, 32'h87654321, 4'hF, 3'b001, 2, 1'b1);
        axi_read(32'h300, 8'd0, 3'b010, 0, -1);
        axi_read(32'h300, 8'd2, 3'b011, 2, -1);

        axi_read(32'h0, 8'd255, 3'b010, 0, -1);

`ifdef L1_RESP_STATS_EN
        check_eq("stat_rd_beats", stat_rd_beats, 32'(exp_rd_beats));
        check_eq("stat_wr_cnt", stat_wr_cnt, 32'(exp_wr_cnt));
        check_eq("stat_err_cnt", {16'd0, stat_err_cnt}, 32'(exp_err_cnt));
`endif

        // Reset with a write response pending and a read burst mid-way.
        axi_write(32'h80, 32'hCAFEF00D, 4'hF, 3'b010, 0, 1'b0);
        axi_read(32'h100, 8'd3, 3'b010, 0, 1);
        do_reset();
        axi_read(32'h80, 8'd0, 3'b010, 0, -1);
        axi_read(32'h100, 8'd3, 3'b010, 2, -1);

        for (int k = 0; k < 60; k++) begin
            op  = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, DEPTH + 3));
            ad  = 32'(idx * 4);
            sz  = ($urandom_range(0, 7) == 0) ? 3'b011 : 3'b010;
            if (op == 0) begin
                axi_write(ad, $urandom, 4'($urandom_range(0, 15)), sz, int'($urandom_range(0, 3)), 1'b1);
            end else begin
                axi_read(ad, 8'($urandom_range(0, 5)), sz, 2, -1);
            end
        end

`ifdef L1_RESP_STATS_EN
        check_eq("stat_rd_beats_end", stat_rd_beats, 32'(exp_rd_beats));
        check_eq("stat_wr_cnt_end", stat_wr_cnt, 32'(exp_wr_cnt));
        check_eq("stat_err_cnt_end", {16'd0, stat_err_cnt}, 32'(exp_err_cnt));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
